alarm_clk_btn_ctrl: RTL

ALARM_CLK_BTN_CTRL -- requirements
Module: alarm_clk_btn_ctrl

---
 rtl/alarm_clk_btn_ctrl.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/alarm_clk_btn_ctrl.sv
// Debounced push-button controller for the alarm clock: press and auto-repeat
// events are latched into an Avalon-MM capture register that drives a level irq.
module alarm_clk_btn_ctrl #(
  parameter int NUM_BTN         = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_RATE     = 5000000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         address,
  input  logic               chipselect,
  input  logic               write_n,
  input  logic [31:0]        writedata,
  output logic [31:0]        readdata,
  input  logic [NUM_BTN-1:0] in_port,
  output logic               irq
);

  localparam int DB_W     = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int HC_W     = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;

  localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DB_W-1:0] DB_ONE     = DB_W'(1);
  localparam logic [HC_W-1:0] DELAY_LAST = HC_W'(REPEAT_DELAY - 1);
  localparam logic [HC_W-1:0] RATE_LAST  = HC_W'(REPEAT_RATE - 1);
  localparam logic [HC_W-1:0] HC_ONE     = HC_W'(1);

  typedef enum logic [1:0] {
    RELEASED = 2'd0,
    HOLD     = 2'd1,
    REPEAT   = 2'd2
  } btn_state_t;

  logic [NUM_BTN-1:0] sync1;
  logic [NUM_BTN-1:0] sync2;
  logic [NUM_BTN-1:0] raw_pressed;
  logic [NUM_BTN-1:0] deb_state;
  logic [NUM_BTN-1:0] db_done;
  logic [NUM_BTN-1:0] deb_rise;
  logic [NUM_BTN-1:0] deb_fall;
  logic [DB_W-1:0]    db_cnt   [NUM_BTN];
  logic [HC_W-1:0]    hold_cnt [NUM_BTN];
  btn_state_t         state    [NUM_BTN];
  logic [NUM_BTN-1:0] evt;

  logic [NUM_BTN-1:0] irq_mask;
  logic [NUM_BTN-1:0] capture;
  logic [NUM_BTN-1:0] repeat_en;
  logic [NUM_BTN-1:0] clr_bits;
  logic [31:0]        rd_mux;
  logic               wr_en;
  logic               unused_wd;

  assign unused_wd   = ^writedata[31:NUM_BTN];
  assign raw_pressed = ACTIVE_LOW ? ~sync2 : sync2;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= in_port;
      sync2 <= sync1;
    end
  end

  // A debounce toggle is decided combinationally so the press event lands in
  // the same cycle deb_state rises.
  always_comb begin
    for (int i = 0; i < NUM_BTN; i++) begin
      db_done[i] = (raw_pressed[i] != deb_state[i]) && (db_cnt[i] == DB_LAST);
    end
    deb_rise = db_done & ~deb_state;
    deb_fall = db_done & deb_state;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      deb_state <= '0;
      for (int i = 0; i < NUM_BTN; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      deb_state <= deb_state ^ db_done;
      for (int i = 0; i < NUM_BTN; i++) begin
        if (raw_pressed[i] == deb_state[i] || db_done[i]) begin
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_ONE;
        end
      end
    end
  end

  // Release always wins over a repeat that would fire in the same cycle.
  always_comb begin
    for (int i = 0; i < NUM_BTN; i++) begin
      evt[i] = 1'b0;
      case (state[i])
        RELEASED: evt[i] = deb_rise[i];
        HOLD:     evt[i] = !deb_fall[i] && repeat_en[i] && (hold_cnt[i] == DELAY_LAST);
        REPEAT:   evt[i] = !deb_fall[i] && repeat_en[i] && (hold_cnt[i] == RATE_LAST);
        default:  evt[i] = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_BTN; i++) begin
        state[i]    <= RELEASED;
        hold_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_BTN; i++) begin
        case (state[i])
          RELEASED: begin
            hold_cnt[i] <= '0;
            if (deb_rise[i]) begin
              state[i] <= HOLD;
            end
          end
          HOLD: begin
            if (deb_fall[i]) begin
              state[i]    <= RELEASED;
              hold_cnt[i] <= '0;
            end else if (hold_cnt[i] == DELAY_LAST) begin
              if (repeat_en[i]) begin
                state[i]    <= REPEAT;
                hold_cnt[i] <= '0;
              end
            end else begin
              hold_cnt[i] <= hold_cnt[i] + HC_ONE;
            end
          end
          REPEAT: begin
            if (deb_fall[i]) begin
              state[i]    <= RELEASED;
              hold_cnt[i] <= '0;
            end else if (!repeat_en[i]) begin
              state[i]    <= HOLD;
              hold_cnt[i] <= DELAY_LAST;
            end else if (hold_cnt[i] == RATE_LAST) begin
              hold_cnt[i] <= '0;
            end else begin
              hold_cnt[i] <= hold_cnt[i] + HC_ONE;
            end
          end
          default: begin
            state[i]    <= RELEASED;
            hold_cnt[i] <= '0;
          end
        endcase
      end
    end
  end

  assign wr_en    = chipselect && !write_n;
  assign clr_bits = (wr_en && address == 2'd2) ? writedata[NUM_BTN-1:0] : '0;

  always_comb begin
    rd_mux = '0;
    case (address)
      2'd0:    rd_mux[NUM_BTN-1:0] = deb_state;
      2'd1:    rd_mux[NUM_BTN-1:0] = irq_mask;
      2'd2:    rd_mux[NUM_BTN-1:0] = capture;
      default: rd_mux[NUM_BTN-1:0] = repeat_en;
    endcase
  end

  // New events are OR-ed in after the clear so a same-cycle event survives.
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_mask  <= '0;
      repeat_en <= '0;
      capture   <= '0;
      readdata  <= '0;
    end else begin
      if (wr_en && address == 2'd1) begin
        irq_mask <= writedata[NUM_BTN-1:0];
      end
      if (wr_en && address == 2'd3) begin
        repeat_en <= writedata[NUM_BTN-1:0];
      end
      capture  <= (capture & ~clr_bits) | evt;
      readdata <= rd_mux;
    end
  end

  assign irq = |(capture & irq_mask);

endmodule
